// File: rtl/pwm_generator.sv
`default_nettype none
// ============================================================================
// Module   : pwm_generator
// Purpose  : Motor-drive PWM stage for the swerve steering motor driver.
//            Applies requested duty ratios only at PWM period boundaries,
//            inserts a dead-time blanking interval on direction reversals,
//            and returns a one-cycle pwm_done pulse when a ratio is applied.
// Ports    : clock         - main clock
//            reset         - synchronous, active-high reset
//            pwm_enable    - run enable; low forces output off
//            pwm_update    - request to apply pwm_ratio/pwm_direction
//            pwm_ratio     - requested high-time, counts out of 256
//            pwm_direction - requested motor direction
//            pwm_done      - one-cycle pulse: requested ratio now active
//            pwm_out       - PWM pin to motor driver
//            motor_dir     - direction pin to motor driver
//            active_ratio  - ratio currently applied
//            debug_signals - {4'b0, dead_cnt_nonzero, state[2:0]}
// Revision : 1.0 - initial release
// ============================================================================
module pwm_generator #(
  parameter int PRESCALE     = 4,
  parameter int DEAD_PERIODS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pwm_enable,
  input  logic       pwm_update,
  input  logic [7:0] pwm_ratio,
  input  logic       pwm_direction,
  output logic       pwm_done,
  output logic       pwm_out,
  output logic       motor_dir,
  output logic [7:0] active_ratio,
  output logic [7:0] debug_signals
);

  localparam int PRESC_W = (PRESCALE < 2) ? 1 : $clog2(PRESCALE);
  localparam int DEAD_W  = (DEAD_PERIODS < 2) ? 1 : $clog2(DEAD_PERIODS + 1);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);
  localparam logic [DEAD_W-1:0]  DEAD_LOAD = DEAD_W'(DEAD_PERIODS);
  localparam logic               NO_DEAD   = (DEAD_PERIODS == 0);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_DEAD = 3'd2
  } state_e;

  state_e              state_q,  state_d;
  logic [PRESC_W-1:0]  presc_q,  presc_d;
  logic [7:0]          count_q,  count_d;
  logic [DEAD_W-1:0]   dead_q,   dead_d;
  logic [7:0]          ratio_q,  ratio_d;
  logic                dir_q,    dir_d;
  logic [7:0]          sratio_q, sratio_d;
  logic                sdir_q,   sdir_d;
  logic                done_q,   done_d;
  logic                out_q,    out_d;

  logic tick;
  logic wrap;

  assign tick = (presc_q == PRESC_MAX);
  assign wrap = tick && (count_q == 8'd255);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      count_q  <= '0;
      dead_q   <= '0;
      ratio_q  <= '0;
      dir_q    <= 1'b0;
      sratio_q <= '0;
      sdir_q   <= 1'b0;
      done_q   <= 1'b0;
      out_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      count_q  <= count_d;
      dead_q   <= dead_d;
      ratio_q  <= ratio_d;
      dir_q    <= dir_d;
      sratio_q <= sratio_d;
      sdir_q   <= sdir_d;
      done_q   <= done_d;
      out_q    <= out_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    count_d  = count_q;
    dead_d   = dead_q;
    ratio_d  = ratio_q;
    dir_d    = dir_q;
    sratio_d = sratio_q;
    sdir_d   = sdir_q;
    done_d   = 1'b0;
    out_d    = 1'b0;

    if (!pwm_enable) begin
      // Drop to IDLE; motor_dir keeps its last value, any pending shadow
      // request is discarded.
      state_d  = ST_IDLE;
      presc_d  = '0;
      count_d  = '0;
      dead_d   = '0;
      ratio_d  = '0;
      sratio_d = '0;
      sdir_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Entry edge: immediate load when an update is pending, no dead time.
          state_d = ST_RUN;
          presc_d = '0;
          count_d = '0;
          if (pwm_update) begin
            ratio_d = pwm_ratio;
            dir_d   = pwm_direction;
            done_d  = 1'b1;
          end else begin
            ratio_d = '0;
          end
        end

        ST_RUN: begin
          out_d = (count_q < ratio_q);
          if (tick) begin
            presc_d = '0;
            count_d = count_q + 8'd1;
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
          if (wrap && pwm_update) begin
            // A reversal is only blanked when the motor is actually driven.
            if ((pwm_direction == dir_q) || (ratio_q == 8'd0) || NO_DEAD) begin
              ratio_d = pwm_ratio;
              dir_d   = pwm_direction;
              done_d  = 1'b1;
            end else begin
              sratio_d = pwm_ratio;
              sdir_d   = pwm_direction;
              dead_d   = DEAD_LOAD;
              state_d  = ST_DEAD;
            end
          end
        end

        ST_DEAD: begin
          if (tick) begin
            presc_d = '0;
            count_d = count_q + 8'd1;
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
          if (wrap) begin
            dead_d = dead_q - DEAD_W'(1);
            if (dead_q == DEAD_W'(1)) begin
              ratio_d = sratio_q;
              dir_d   = sdir_q;
              done_d  = 1'b1;
              state_d = ST_RUN;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          presc_d = '0;
          count_d = '0;
          dead_d  = '0;
          ratio_d = '0;
        end
      endcase
    end
  end

  assign pwm_done      = done_q;
  assign pwm_out       = out_q;
  assign motor_dir     = dir_q;
  assign active_ratio  = ratio_q;
  assign debug_signals = {4'b0000, (dead_q != '0), state_q};

endmodule
`default_nettype wire

// File: doc/pwm_generator.md
Name: pwm_generator

Overview:
- Motor-drive PWM stage directly downstream of the angle-to-PWM controller.
- Consumes pwm_enable, pwm_update, pwm_ratio and pwm_direction, and produces the physical PWM pin and direction pin for the swerve steering motor driver.
- Returns a one-cycle pwm_done pulse each time a requested ratio is applied, which closes the controller's update handshake.
- Ratios change only at period boundaries, and a direction reversal inserts a dead-time blanking interval.

Parameters:
PRESCALE, 4, clocks per PWM count tick (>=1); PWM period = 256*PRESCALE clocks
DEAD_PERIODS, 2, full PWM periods of forced-low output on a direction reversal (0 = no dead time)

Ports:
clock  input  1  main clock
reset  input  1  synchronous, active-high reset
pwm_enable  input  1  run enable; low forces output off
pwm_update  input  1  request to apply pwm_ratio/pwm_direction at the next boundary
pwm_ratio  input  8  requested high-time, counts out of 256
pwm_direction  input  1  requested motor direction
pwm_done  output  1  one-cycle pulse: the requested ratio is now active
pwm_out  output  1  PWM pin to motor driver
motor_dir  output  1  direction pin to motor driver
active_ratio  output  8  ratio currently applied (debug)
debug_signals  output  8  {4'b0, dead_cnt_nonzero, state[2:0]}

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset values: pwm_out=0, motor_dir=0, pwm_done=0, active_ratio=0, state=IDLE, prescale counter=0, period count=0, dead counter=0.
- Prescaler: counts 0..PRESCALE-1. tick=1 when it equals PRESCALE-1, then it wraps to 0. PRESCALE=1 gives tick every cycle.
- Period counter (8 bit): advances on tick. wrap = tick & count==255, and the counter returns to 0.
- pwm_out: registered; pwm_out <= (state==RUN) & (count < active_ratio).
  - One-cycle lag behind the count.
  - Ratio 0 gives constant low; ratio 255 gives high for 255 of 256 counts.
- pwm_done: registered; high for exactly one cycle following the edge that loads active_ratio. Never high in IDLE except on the immediate-load edge described under IDLE.
- States:
  - IDLE:
    - Output low; counters held at 0.
    - If pwm_enable & pwm_update, on that edge: active_ratio<=pwm_ratio, motor_dir<=pwm_direction, pwm_done<=1, go RUN with count=0. This is an immediate load with no dead time.
    - If pwm_enable without pwm_update: go RUN with active_ratio=0.
  - RUN: at each wrap where pwm_update=1:
    - If pwm_direction==motor_dir, or active_ratio==0, or DEAD_PERIODS==0: active_ratio<=pwm_ratio, motor_dir<=pwm_direction, pwm_done<=1.
    - Otherwise: latch pwm_ratio/pwm_direction into shadow regs, motor_dir unchanged, dead counter<=DEAD_PERIODS, go DEAD. No pwm_done.
    - Wrap with pwm_update=0: active_ratio retained; no pwm_done.
  - DEAD:
    - pwm_out forced 0. pwm_update is ignored, and the shadow is not overwritten.
    - Dead counter decrements on each wrap.
    - At the wrap where it reaches 0 (i.e. after DEAD_PERIODS full periods), on that edge: motor_dir<=shadow dir, active_ratio<=shadow ratio, pwm_done<=1, go RUN.
- pwm_enable low in any state: on that edge go IDLE and apply IDLE reset values, except that motor_dir holds. A pending shadow is discarded and no pwm_done is issued.
- pwm_update is sampled only at wrap (or on the IDLE entry edge). Changes to pwm_ratio between wraps have no effect.
- The controller's pattern (update held until done, dropped one cycle, reasserted) yields exactly one application per period; repeated identical updates are legal and each produces pwm_done.
- reset while in DEAD or mid-period: all state returns to the reset values on that edge, and the shadow is discarded.
- Widths: all compares are unsigned 8 bit; the dead counter is wide enough for DEAD_PERIODS; no overflow paths.

Test Plan:
- PRESCALE=1, reset then enable=1 with update=1, ratio=64, dir=0 -> pwm_done pulses 1 cycle after the enable edge; pwm_out is high 64 cycles and low 192 per 256-cycle period; motor_dir=0.
- In RUN at ratio 64, ratio=200 with update held high until done, then low -> change takes effect only at the next wrap, pwm_done pulses exactly once at that wrap, and subsequent periods show 200 high / 56 low.
- Ratio=0 and ratio=255 applied -> constant low for the whole period; high for 255 of 256 cycles, low for 1.
- DEAD_PERIODS=2, active ratio 128, dir=0, update ratio=100 with dir=1 -> at the wrap motor_dir stays 0 and pwm_out is low for 512 cycles. At the second subsequent wrap motor_dir=1, active_ratio=100, pwm_done pulses; pwm_update asserted during DEAD is ignored.
- enable dropped mid-DEAD -> next cycle pwm_out=0, active_ratio=0, state IDLE, no pwm_done; re-enable with update ratio=50, dir=1 -> immediate load, pwm_done pulses, no dead time.
- PRESCALE=4, ratio=10 -> period of 1024 cycles, pwm_out high for 40 cycles; a synchronous reset asserted mid-period -> all outputs 0 on the cycle after the reset edge.
